// File: rtl/instr_mem_pipe_if.sv
// Fetch-side request/response bundle for instr_mem_pipe.
// master: PC/fetch logic driving requests and consuming responses.
// slave : the instruction memory.
interface instr_mem_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_instr;
   logic [ADDR_W-1:0] resp_addr;
   logic              resp_fault;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_instr, resp_addr, resp_fault
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_instr, resp_addr, resp_fault
   );
endinterface

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction memory for the fetch stage: registered
// response with valid/ready back-pressure, runtime program-load port and a
// zero-fill sweep after every reset.
// Optional feature macro: IMEM_FAULT_CHECK_EN (address fault detection;
// when undefined, addresses wrap modulo DEPTH words and resp_fault is 0).
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | zero-fill sweep, one word per cycle; fetches and loads ignored
// RUN   | fetches and program loads accepted
module instr_mem_pipe #(
   parameter int                   DATA_W    = 32,
   parameter int                   DEPTH     = 256,
   parameter int                   ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
   localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   instr_mem_pipe_if.slave     fetch,
   input  logic                ld_en,
   output logic                ld_ready,
   input  logic [IDX_W-1:0]    ld_index,
   input  logic [DATA_W-1:0]   ld_data,
   output logic                init_done
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [IDX_W-1:0]  ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              run;
   logic              accept;
   logic              fault;
   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] word_off;
   logic [IDX_W-1:0]  idx;

   assign run       = (state == ST_RUN);
   assign ld_ready  = run;
   assign init_done = run;

   assign fetch.req_ready = run && (!fetch.resp_valid || fetch.resp_ready);
   assign accept          = fetch.req_valid && fetch.req_ready;

   assign off      = fetch.req_addr - BASE_ADDR;
   assign word_off = off >> 2;
   assign idx      = word_off[IDX_W-1:0];

`ifdef IMEM_FAULT_CHECK_EN
   assign fault = (fetch.req_addr[1:0] != 2'b00)
               || (fetch.req_addr < BASE_ADDR)
               || (word_off >= ADDR_W'(DEPTH));
`else
   // Upper word-offset bits are dropped on purpose: addresses wrap.
   logic unused_word_hi;
   assign unused_word_hi = ^word_off[ADDR_W-1:IDX_W];
   assign fault          = 1'b0;
`endif

   // Sequencer: sweep pointer walks every word once, then hand over to RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         ptr   <= '0;
      end else if (state == ST_INIT) begin
         ptr <= ptr + IDX_W'(1);
         if (ptr == IDX_W'(DEPTH - 1)) begin
            state <= ST_RUN;
         end
      end
   end

   // Memory writes: zero-fill during INIT, program loads during RUN.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            mem[ptr] <= '0;
         end else if (ld_en) begin
            mem[ld_index] <= ld_data;
         end
      end
   end

   // Response register: a load in the same cycle lands after this read, so a
   // colliding fetch returns the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch.resp_valid <= 1'b0;
         fetch.resp_instr <= '0;
         fetch.resp_addr  <= '0;
         fetch.resp_fault <= 1'b0;
      end else if (accept) begin
         fetch.resp_valid <= 1'b1;
         fetch.resp_addr  <= fetch.req_addr;
         fetch.resp_fault <= fault;
         fetch.resp_instr <= fault ? '0 : mem[idx];
      end else if (fetch.resp_ready) begin
         fetch.resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_instr_mem_pipe;

   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 32;
   localparam int          DEPTH  = 256;
   localparam int          IDX_W  = $clog2(DEPTH);
`ifdef IMEM_FAULT_CHECK_EN
   localparam logic [31:0] BASE   = 32'h0040_0000;
`else
   localparam logic [31:0] BASE   = 32'h0000_0000;
`endif

   logic              clk;
   logic              rst;
   logic              ld_en;
   logic              ld_ready;
   logic [IDX_W-1:0]  ld_index;
   logic [DATA_W-1:0] ld_data;
   logic              init_done;

   instr_mem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

   instr_mem_pipe #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fetch     (fif),
      .ld_en     (ld_en),
      .ld_ready  (ld_ready),
      .ld_index  (ld_index),
      .ld_data   (ld_data),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory image, readiness and the expected response.
   logic [31:0] m_mem [DEPTH];
   bit          m_run;
   int          m_cnt;
   bit          m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_addr;
   bit          m_fault;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_run   = 0;
      m_cnt   = 0;
      m_valid = 0;
      m_instr = '0;
      m_addr  = '0;
      m_fault = 0;
   endfunction

   // Byte address to word index and fault flag, from plain arithmetic.
   function automatic void addr_map(input logic [31:0] a, output int idx, output bit f);
      longint off;
      off = longint'(a) - longint'(BASE);
`ifdef IMEM_FAULT_CHECK_EN
      f   = (a % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
      idx = f ? 0 : int'(off / 4);
`else
      if (off < 0) off = off + 64'h1_0000_0000;
      f   = 0;
      idx = int'((off / 4) % DEPTH);
`endif
   endfunction

   // One clock cycle: drive at negedge, check readiness, advance the model,
   // then check the response just after the rising edge.
   task automatic cycle(input bit r, input bit v, input logic [31:0] a, input bit rr,
                        input bit le, input logic [IDX_W-1:0] li, input logic [31:0] ld);
      bit exp_rdy;
      int idx;
      bit f;
      @(negedge clk);
      rst            = r;
      fif.req_valid  = v;
      fif.req_addr   = a;
      fif.resp_ready = rr;
      ld_en          = le;
      ld_index       = li;
      ld_data        = ld;
      #1;
      exp_rdy = m_run && (!m_valid || rr);
      chk("req_ready", 32'(fif.req_ready), 32'(exp_rdy));
      chk("ld_ready",  32'(ld_ready),      32'(m_run));
      chk("init_done", 32'(init_done),     32'(m_run));
      if (r) begin
         model_reset();
      end else begin
         if (v && exp_rdy) begin
            addr_map(a, idx, f);
            m_valid = 1;
            m_addr  = a;
            m_fault = f;
            m_instr = f ? 32'h0 : m_mem[idx];
         end else if (rr) begin
            m_valid = 0;
         end
         if (m_run) begin
            if (le) m_mem[int'(li)] = ld;
         end else begin
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("resp_valid", 32'(fif.resp_valid), 32'(m_valid));
      if (m_valid || r) begin
         chk("resp_instr", fif.resp_instr,      m_instr);
         chk("resp_addr",  fif.resp_addr,       m_addr);
         chk("resp_fault", 32'(fif.resp_fault), 32'(m_fault));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 1, 0, '0, 32'h0);
   endtask

   task automatic fetch_at(input logic [31:0] a);
      cycle(0, 1, a, 1, 0, '0, 32'h0);
   endtask

   task automatic load_at(input int i, input logic [31:0] d);
      cycle(0, 0, 32'h0, 1, 1, IDX_W'(i), d);
   endtask

   // Sweep with junk on the request and load inputs, which must be ignored.
   task automatic sweep_with_noise();
      for (int i = 0; i < DEPTH; i++)
         cycle(0, bit'($urandom % 2), BASE + 32'($urandom_range(0, DEPTH - 1) * 4), 1,
               bit'($urandom % 2), IDX_W'($urandom), $urandom);
   endtask

   initial begin
      rst            = 1'b1;
      fif.req_valid  = 1'b0;
      fif.req_addr   = '0;
      fif.resp_ready = 1'b1;
      ld_en          = 1'b0;
      ld_index       = '0;
      ld_data        = '0;
      model_reset();

      // Reset values, then the first sweep.
      cycle(1, 0, 32'h0, 1, 0, '0, 32'h0);
      cycle(1, 1, BASE, 1, 1, '0, 32'h1234_5678);
      sweep_with_noise();
      chk("init_done_after_sweep", 32'(init_done), 32'h1);

      // Reset re-zeroes memory.
      load_at(5, 32'hDEAD_BEEF);
      fetch_at(BASE + 32'h14);
      chk("pre_reset_word", fif.resp_instr, 32'hDEAD_BEEF);
      cycle(1, 0, 32'h0, 0, 0, '0, 32'h0);
      sweep_with_noise();
      fetch_at(BASE + 32'h14);
      chk("sweep_zero", fif.resp_instr, 32'h0);
      idle(1);

      // Load then back-to-back fetch.
      load_at(10, 32'h2008_0002);
      load_at(11, 32'hAC85_0000);
      fetch_at(BASE + 32'h28);
      chk("fetch_28", fif.resp_instr, 32'h2008_0002);
      fetch_at(BASE + 32'h2C);
      chk("fetch_2c", fif.resp_instr, 32'hAC85_0000);
      chk("echo_2c",  fif.resp_addr,  BASE + 32'h2C);
      idle(1);

      // Back-pressure: response held, second request waits.
      fetch_at(BASE + 32'h28);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, BASE + 32'h2C, 0, 0, '0, 32'h0);
         chk("bp_hold", fif.resp_instr, 32'h2008_0002);
      end
      cycle(0, 1, BASE + 32'h2C, 1, 0, '0, 32'h0);
      chk("bp_release", fif.resp_instr, 32'hAC85_0000);
      idle(1);

      // Read-before-write collision.
      load_at(12, 32'h8C86_0000);
      cycle(0, 1, BASE + 32'h30, 1, 1, IDX_W'(12), 32'h1111_1111);
      chk("collide_old", fif.resp_instr, 32'h8C86_0000);
      fetch_at(BASE + 32'h30);
      chk("collide_new", fif.resp_instr, 32'h1111_1111);
      idle(1);

`ifdef IMEM_FAULT_CHECK_EN
      load_at(0, 32'hCAFE_F00D);
      fetch_at(32'h0040_0002);
      chk("fault_misalign", 32'(fif.resp_fault), 32'h1);
      chk("fault_misalign_nop", fif.resp_instr, 32'h0);
      fetch_at(32'h003F_FFFC);
      chk("fault_below", 32'(fif.resp_fault), 32'h1);
      chk("fault_below_nop", fif.resp_instr, 32'h0);
      fetch_at(32'h0040_0400);
      chk("fault_above", 32'(fif.resp_fault), 32'h1);
      chk("fault_above_nop", fif.resp_instr, 32'h0);
      fetch_at(32'h0040_0000);
      chk("fault_ok", fif.resp_instr, 32'hCAFE_F00D);
`else
      load_at(0, 32'hCAFE_F00D);
      fetch_at(BASE + 32'h400);
      chk("wrap_word", fif.resp_instr, 32'hCAFE_F00D);
      chk("wrap_fault", 32'(fif.resp_fault), 32'h0);
      load_at(3, 32'h0BAD_C0DE);
      fetch_at(BASE + 32'h0E);
      chk("misalign_word", fif.resp_instr, 32'h0BAD_C0DE);
`endif
      idle(1);

      // Randomized traffic with a mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a;
         if ($urandom % 5 != 0)
            a = BASE + 32'($urandom_range(0, 31) * 4);
         else if ($urandom % 2 == 0)
            a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
         else
            a = $urandom;
         cycle(i == 1500, bit'($urandom % 4 != 0), a, bit'($urandom % 4 != 0),
               bit'($urandom % 3 == 0), IDX_W'($urandom_range(0, 31)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
